// File: rtl/cordic_pkg.sv
// cordic_pkg: shared float field layout, constants and classification for the angle datapath
package cordic_pkg;

    localparam int FP_BIAS  = 127;
    localparam int FP_MAN_W = 23;

    typedef struct packed {
        logic                sign;
        logic [7:0]          exp;
        logic [FP_MAN_W-1:0] man;
    } float_t;

    typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fp_class_e;

endpackage

// File: rtl/fp_align_shift.sv
// fp_align_shift: aligns a 24-bit mantissa by signed k into a WIDTH-bit magnitude with guard, sticky and overflow
module fp_align_shift #(
    parameter int WIDTH = 23
) (
    input  logic [23:0]        i_man,
    input  logic signed [9:0]  i_k,
    output logic [WIDTH-1:0]   o_mag,
    output logic               o_guard,
    output logic               o_sticky,
    output logic               o_ovf
);

    logic [WIDTH+23:0] w_l;
    logic [WIDTH+23:0] w_i;
    logic [49:0]       w_r;
    logic [4:0]        w_sh;

    // left shift for k >= 0; right shift clamped at 26 so the whole mantissa lands in sticky
    always_comb begin
        w_sh     = (i_k < -10'sd25) ? 5'd26 : 5'(-i_k);
        w_l      = (WIDTH+24)'(i_man) << i_k[4:0];
        w_r      = {i_man, 26'b0} >> w_sh;
        w_i      = (WIDTH+24)'(w_r[49:26]);
        o_mag    = (i_k >= 0) ? w_l[WIDTH-1:0] : w_i[WIDTH-1:0];
        o_guard  = (i_k >= 0) ? 1'b0 : w_r[25];
        o_sticky = (i_k >= 0) ? 1'b0 : |w_r[24:0];
        o_ovf    = (i_k >= 0) ? ((i_k >= $signed(10'(WIDTH))) || (|w_l[WIDTH+23:WIDTH]))
                              : |w_i[WIDTH+23:WIDTH];
    end

endmodule

// File: rtl/float_to_fixed_pipe.sv
// float_to_fixed_pipe: 3-stage IEEE-754 single to signed Q(INTS).(FRACS); FTOF_ROUND_NEAREST_EN selects round-to-nearest-even
module float_to_fixed_pipe
    import cordic_pkg::*;
#(
    parameter int INTS  = 1,
    parameter int FRACS = 21,
    parameter int WIDTH = INTS + FRACS + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_float,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_fixed,
    output logic             out_ovf,
    output logic             out_uf,
    output logic             out_nan
);

`ifdef FTOF_ROUND_NEAREST_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    float_t            w_f;
    fp_class_e         w_cls;
    logic signed [9:0] w_k;
    logic              w_adv;

    logic              r1_valid, r1_sign, r1_dnz;
    fp_class_e         r1_cls;
    logic [23:0]       r1_man;
    logic signed [9:0] r1_k;

    logic [WIDTH-1:0]  w_mag;
    logic              w_guard, w_sticky, w_shovf;

    logic              r2_valid, r2_sign, r2_dnz, r2_guard, r2_sticky, r2_ovf;
    fp_class_e         r2_cls;
    logic [WIDTH-1:0]  r2_mag;

    logic              w_inc, w_big;
    logic [WIDTH:0]    w_rnd, w_lim;
    logic [WIDTH-1:0]  w_sat, w_fix;
    logic              w_ovf_f, w_uf_f, w_nan_f;

    logic              r_valid, r_ovf, r_uf, r_nan;
    logic [WIDTH-1:0]  r_fixed;

    assign w_adv     = !r_valid || out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_valid;
    assign out_fixed = r_fixed;
    assign out_ovf   = r_ovf;
    assign out_uf    = r_uf;
    assign out_nan   = r_nan;
    assign w_f       = in_float;

    // S1 decode: classify the word and form the alignment shift k = e + FRACS - 23
    always_comb begin
        w_cls = (w_f.exp == 8'd0)   ? ZERO :
                (w_f.exp == 8'hFF)  ? ((w_f.man != '0) ? NAN : INF) : NORM;
        w_k   = $signed({2'b00, w_f.exp}) - $signed(10'(FP_BIAS + FP_MAN_W - FRACS));
    end

    // S1 register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_valid <= 1'b0;
            r1_sign  <= 1'b0;
            r1_dnz   <= 1'b0;
            r1_cls   <= ZERO;
            r1_man   <= '0;
            r1_k     <= '0;
        end else if (w_adv) begin
            r1_valid <= in_valid;
            r1_sign  <= w_f.sign;
            r1_dnz   <= (w_f.exp == 8'd0) && (w_f.man != '0);
            r1_cls   <= w_cls;
            r1_man   <= {1'b1, w_f.man};
            r1_k     <= w_k;
        end
    end

    fp_align_shift #(.WIDTH(WIDTH)) u_align (
        .i_man    (r1_man),
        .i_k      (r1_k),
        .o_mag    (w_mag),
        .o_guard  (w_guard),
        .o_sticky (w_sticky),
        .o_ovf    (w_shovf)
    );

    // S2 register: aligned magnitude with guard/sticky
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r2_valid  <= 1'b0;
            r2_sign   <= 1'b0;
            r2_dnz    <= 1'b0;
            r2_cls    <= ZERO;
            r2_mag    <= '0;
            r2_guard  <= 1'b0;
            r2_sticky <= 1'b0;
            r2_ovf    <= 1'b0;
        end else if (w_adv) begin
            r2_valid  <= r1_valid;
            r2_sign   <= r1_sign;
            r2_dnz    <= r1_dnz;
            r2_cls    <= r1_cls;
            r2_mag    <= w_mag;
            r2_guard  <= w_guard;
            r2_sticky <= w_sticky;
            r2_ovf    <= w_shovf;
        end
    end

    // S3 round the magnitude, then saturate against the signed limit, then negate
    always_comb begin
        w_inc   = RNE && r2_guard && (r2_sticky || r2_mag[0]);
        w_rnd   = {1'b0, r2_mag} + (WIDTH+1)'(w_inc);
        w_lim   = ((WIDTH+1)'(1) << (WIDTH-1)) - (WIDTH+1)'(!r2_sign);
        w_big   = r2_ovf || (w_rnd > w_lim);
        w_sat   = r2_sign ? (WIDTH'(1) << (WIDTH-1)) : ~(WIDTH'(1) << (WIDTH-1));
        w_fix   = (r2_cls == INF)  ? w_sat :
                  (r2_cls != NORM) ? '0 :
                  w_big            ? w_sat :
                  r2_sign          ? WIDTH'(0) - w_rnd[WIDTH-1:0] : w_rnd[WIDTH-1:0];
        w_ovf_f = (r2_cls == INF) || ((r2_cls == NORM) && w_big);
        w_uf_f  = (r2_cls == ZERO) ? r2_dnz : ((r2_cls == NORM) && !w_big && (w_rnd == '0));
        w_nan_f = (r2_cls == NAN);
    end

    // S3 output register, held while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_fixed <= '0;
            r_ovf   <= 1'b0;
            r_uf    <= 1'b0;
            r_nan   <= 1'b0;
        end else if (w_adv) begin
            r_valid <= r2_valid;
            r_fixed <= w_fix;
            r_ovf   <= w_ovf_f;
            r_uf    <= w_uf_f;
            r_nan   <= w_nan_f;
        end
    end

endmodule
